fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Drives the PC_enable / PC_source / PC_jump controls of the dual-issue instruction fetch stage.
//  Sequences sequential fetch, hazard stalls, taken-branch redirects with wrong-path flush, and stop/restart.
//  Sits between the hazard unit, the execute-stage branch resolver and the fetch stage.
//  Reports the validity of each fetched instruction pair, plus a bubble counter for performance debug.
// PARAMETERS
//  bitsize       11  PC width (must match the fetch stage)
//  FLUSH_CYCLES  2   cycles of squash after a redirect, range 1..7
//  CNT_W         16  bubble counter width
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-low reset
//  stall          in   1        hazard unit: hold the current fetch pair
//  branch_taken   in   1        execute stage: resolved taken branch this cycle
//  branch_target  in   bitsize  redirect PC; valid when branch_taken=1
//  stop           in   1        decode: stop instruction present
//  restart        in   1        external resume from HALT
//  PC_enable      out  1        PC register load enable
//  PC_source      out  1        0 = PC adder, 1 = PC_jump
//  PC_jump        out  bitsize  redirect PC to the fetch mux
//  fetch_valid    out  1        instruction pair leaving fetch is valid
//  flush          out  1        squash the IF/ID and ID/EX contents
//  halted         out  1        1 while in HALT
//  bubble_count   out  CNT_W    saturating count of non-productive cycles
// BEHAVIOUR
//  - States: RUN=2'b00, STALL=2'b01, REDIRECT=2'b10, HALT=2'b11. The state and a 3-bit flush counter are registered.
//  - All other outputs are combinational from the state and the inputs.
//  - While reset=0 (asynchronous): state=RUN, counter=0, bubble_count=0.
//    Also while reset=0: PC_enable=0, PC_source=0, PC_jump=0, fetch_valid=0, flush=0, halted=0.
//  - Priority in every state: branch_taken > stop > stall > restart.
//  - Redirect action (RUN, STALL or HALT with branch_taken=1): PC_enable=1, PC_source=1, PC_jump=branch_target, flush=1.
//    Redirect action, cont.: counter<=FLUSH_CYCLES-1. Next state is REDIRECT, or RUN if FLUSH_CYCLES==1.
//  - PC_jump=branch_target whenever branch_taken=1, otherwise 0. PC_source=1 only during the redirect cycle.
//  - RUN: stop -> PC_enable=0, next HALT. stall -> PC_enable=0, next STALL. Otherwise PC_enable=1, PC_source=0.
//    fetch_valid=1 in RUN.
//  - STALL: fetch_valid=1 (the held pair is still valid). stop -> HALT.
//    stall still asserted -> PC_enable=0, stay in STALL.
//    stall dropped -> PC_enable=1 in that same cycle, next RUN (zero-cycle release).
//  - REDIRECT: flush=1, fetch_valid=0, PC_enable=1, PC_source=0. branch_taken, stop and stall are ignored (wrong path).
//    The counter decrements each cycle. Counter==0 in this cycle -> next RUN.
//  - HALT: PC_enable=0, fetch_valid=0, halted=1. restart -> next RUN. branch_taken -> redirect (the stop was wrong-path).
//  - bubble_count increments on every clk edge where PC_enable==0 or flush==1 (reset excluded).
//    It saturates at all-ones and never wraps.
//  - Reset asserted mid-REDIRECT or mid-STALL returns the block immediately to reset values; no pending redirect survives.
//  - Latency: a redirect loads the PC on the edge after branch_taken is seen.
//    The first valid target pair appears FLUSH_CYCLES cycles later (fetch_valid).
// TESTING
//  1. Reset release, idle inputs, 5 cycles -> PC_enable=1, PC_source=0, fetch_valid=1, bubble_count=0.
//  2. stall high for 3 cycles -> PC_enable=0 for 3 cycles, fetch_valid=1.
//     2 (cont.) -> PC_enable=1 on the cycle stall drops; bubble_count=3.
//  3. branch_taken with branch_target=11'h1A4 in RUN -> PC_jump=11'h1A4, PC_source=1, flush=1 that cycle.
//     3 (cont.) -> flush=1 and fetch_valid=0 for 2 more cycles, then RUN; bubble_count=3.
//  4. In REDIRECT, pulse branch_taken, stop and stall -> all ignored; RUN is reached on schedule.
//  5. stop and stall together -> HALT, halted=1, PC_enable=0.
//     5 (cont.) restart -> RUN next cycle. 5 (cont.) branch_taken while in HALT -> redirect, no restart needed.
//  6. reset pulsed low mid-REDIRECT, asynchronous to clk -> outputs drop to reset values immediately.
//     6 (cont.) After release -> RUN with no residual flush.
//     6 (cont.) Force bubble_count near all-ones -> it saturates, no wrap.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Controls the dual-issue fetch stage. It sequences sequential fetch,
//   hazard stalls, taken-branch redirects with a wrong-path squash window,
//   and stop/restart. It reports fetch-pair validity and keeps a saturating
//   count of bubble cycles for performance debug.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   stall         in   hazard unit: hold the current fetch pair
//   branch_taken  in   execute stage: resolved taken branch this cycle
//   branch_target in   redirect PC, valid while branch_taken=1
//   stop          in   decode: stop instruction present
//   restart       in   external resume from HALT
//   PC_enable     out  PC register load enable
//   PC_source     out  0 = PC adder, 1 = PC_jump
//   PC_jump       out  redirect PC to the fetch mux
//   fetch_valid   out  instruction pair leaving fetch is valid
//   flush         out  squash IF/ID and ID/EX
//   halted        out  1 while in HALT
//   bubble_count  out  saturating count of non-productive cycles
//   dbg_state     out  current FSM state (RUN/STALL/REDIRECT/HALT)
//
// Handshake: none. Every input is a level sampled each cycle. Priority in
// every state is branch_taken > stop > stall > restart. In REDIRECT, all
// inputs except reset are ignored.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int bitsize      = 11,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [bitsize-1:0] branch_target,
   input  logic               stop,
   input  logic               restart,
   output logic               PC_enable,
   output logic               PC_source,
   output logic [bitsize-1:0] PC_jump,
   output logic               fetch_valid,
   output logic               flush,
   output logic               halted,
   output logic [CNT_W-1:0]   bubble_count,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_STALL    = 2'b01,
      S_REDIRECT = 2'b10,
      S_HALT     = 2'b11
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   // With a single squash cycle, the redirect cycle is the whole squash.
   localparam state_t REDIRECT_NEXT = (FLUSH_CYCLES == 1) ? S_RUN : S_REDIRECT;

   state_t           r_state;
   state_t           w_next_state;
   logic [2:0]       r_flush_cnt;
   logic [2:0]       w_flush_cnt_next;
   logic [CNT_W-1:0] r_bubble;

   logic w_pc_enable;
   logic w_pc_source;
   logic w_fetch_valid;
   logic w_flush;
   logic w_halted;
   logic w_bubble;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_RUN;
         r_flush_cnt <= 3'd0;
      end else begin
         r_state     <= w_next_state;
         r_flush_cnt <= w_flush_cnt_next;
      end
   end

   always_comb begin
      w_next_state     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      w_pc_enable      = 1'b0;
      w_pc_source      = 1'b0;
      w_fetch_valid    = 1'b0;
      w_flush          = 1'b0;
      w_halted         = 1'b0;

      case (r_state)
         S_RUN, S_STALL: begin
            // A held pair in STALL is still valid, so both states present it.
            w_fetch_valid = 1'b1;
            if (branch_taken) begin
               w_pc_enable      = 1'b1;
               w_pc_source      = 1'b1;
               w_flush          = 1'b1;
               w_flush_cnt_next = FLUSH_LOAD;
               w_next_state     = REDIRECT_NEXT;
            end else if (stop) begin
               w_next_state = S_HALT;
            end else if (stall) begin
               w_next_state = S_STALL;
            end else begin
               // Zero-cycle release: the PC loads in the cycle stall drops.
               w_pc_enable  = 1'b1;
               w_next_state = S_RUN;
            end
         end

         S_REDIRECT: begin
            w_flush     = 1'b1;
            w_pc_enable = 1'b1;
            if (r_flush_cnt == 3'd0) begin
               w_next_state = S_RUN;
            end else begin
               w_flush_cnt_next = r_flush_cnt - 3'd1;
            end
         end

         S_HALT: begin
            w_halted = 1'b1;
            // A taken branch here means the stop itself was on the wrong path.
            if (branch_taken) begin
               w_pc_enable      = 1'b1;
               w_pc_source      = 1'b1;
               w_flush          = 1'b1;
               w_flush_cnt_next = FLUSH_LOAD;
               w_next_state     = REDIRECT_NEXT;
            end else if (stop || stall) begin
               w_next_state = S_HALT;
            end else if (restart) begin
               w_next_state = S_RUN;
            end
         end

         default: begin
            w_next_state = S_RUN;
         end
      endcase
   end

   assign w_bubble = !w_pc_enable || w_flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bubble <= '0;
      end else if (w_bubble && (r_bubble != '1)) begin
         r_bubble <= r_bubble + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // The outputs are forced low while reset is held, independent of the clock.
   assign PC_enable    = reset & w_pc_enable;
   assign PC_source    = reset & w_pc_source;
   assign fetch_valid  = reset & w_fetch_valid;
   assign flush        = reset & w_flush;
   assign halted       = reset & w_halted;
   assign PC_jump      = (reset && branch_taken) ? branch_target : '0;
   assign bubble_count = r_bubble;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   localparam int BW      = 11;
   localparam int FC      = 2;
   localparam int CW      = 6;
   localparam int BUB_MAX = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic          stall;
   logic          branch_taken;
   logic [BW-1:0] branch_target;
   logic          stop;
   logic          restart;
   logic          PC_enable;
   logic          PC_source;
   logic [BW-1:0] PC_jump;
   logic          fetch_valid;
   logic          flush;
   logic          halted;
   logic [CW-1:0] bubble_count;
   logic [1:0]    dbg_state;

   fetch_sequencer #(.bitsize(BW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .stop         (stop),
      .restart      (restart),
      .PC_enable    (PC_enable),
      .PC_source    (PC_source),
      .PC_jump      (PC_jump),
      .fetch_valid  (fetch_valid),
      .flush        (flush),
      .halted       (halted),
      .bubble_count (bubble_count),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // reference model: squash cycles remaining, halted flag, bubble tally
   int m_flush_left;
   bit m_halt;
   int m_bub;

   // outputs captured at the last sampling point
   logic          cap_pe, cap_ps, cap_fl, cap_fv, cap_ha;
   logic [BW-1:0] cap_jump;
   logic [CW-1:0] cap_bub;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_flush_left = 0;
      m_halt       = 1'b0;
      m_bub        = 0;
   endtask

   // One clock cycle: drive inputs, predict outputs, check at negedge,
   // advance the model at the posedge.
   task automatic cyc(input bit bt, input logic [BW-1:0] tg, input bit sp,
                      input bit st, input bit rs);
      bit e_pe, e_ps, e_fl, e_fv, e_ha;
      int nf;
      bit nh;
      branch_taken  = bt;
      branch_target = tg;
      stop          = sp;
      stall         = st;
      restart       = rs;
      nf = m_flush_left;
      nh = m_halt;
      e_ps = 1'b0;
      e_fl = 1'b0;
      if (m_flush_left > 0) begin
         // wrong-path squash window: everything but reset is ignored
         e_pe = 1'b1; e_fv = 1'b0; e_ha = 1'b0; e_fl = 1'b1;
         nf = m_flush_left - 1;
      end else begin
         e_fv = !m_halt;
         e_ha = m_halt;
         if (bt) begin
            e_pe = 1'b1; e_ps = 1'b1; e_fl = 1'b1;
            nf = (FC == 1) ? 0 : FC;
            nh = 1'b0;
         end else if (sp) begin
            e_pe = 1'b0; nh = 1'b1;
         end else if (st) begin
            e_pe = 1'b0;
         end else if (m_halt) begin
            e_pe = 1'b0;
            if (rs) nh = 1'b0;
         end else begin
            e_pe = 1'b1;
         end
      end
      @(negedge clk);
      cap_pe = PC_enable; cap_ps = PC_source; cap_fl = flush;
      cap_fv = fetch_valid; cap_ha = halted; cap_jump = PC_jump;
      cap_bub = bubble_count;
      chk("pc_enable",   32'(cap_pe),   32'(e_pe));
      chk("pc_source",   32'(cap_ps),   32'(e_ps));
      chk("flush",       32'(cap_fl),   32'(e_fl));
      chk("fetch_valid", 32'(cap_fv),   32'(e_fv));
      chk("halted",      32'(cap_ha),   32'(e_ha));
      chk("pc_jump",     32'(cap_jump), bt ? 32'(tg) : 32'd0);
      chk("bubble",      32'(cap_bub),  32'(m_bub));
      @(posedge clk);
      if ((!e_pe || e_fl) && m_bub < BUB_MAX) m_bub = m_bub + 1;
      m_flush_left = nf;
      m_halt       = nh;
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pe"},   32'(PC_enable),    32'd0);
      chk({tag, "_ps"},   32'(PC_source),    32'd0);
      chk({tag, "_jump"}, 32'(PC_jump),      32'd0);
      chk({tag, "_fv"},   32'(fetch_valid),  32'd0);
      chk({tag, "_fl"},   32'(flush),        32'd0);
      chk({tag, "_ha"},   32'(halted),       32'd0);
      chk({tag, "_bub"},  32'(bubble_count), 32'd0);
   endtask

   int bub_before;

   initial begin
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      stop = 1'b0; restart = 1'b0;
      model_reset();
      #2;
      chk_reset_outputs("por");
      branch_taken = 1'b1; branch_target = 11'h155;
      #1;
      chk("por_jump_gated", 32'(PC_jump), 32'd0);
      branch_taken = 1'b0; branch_target = '0;
      #8 reset = 1'b1;   // released at t=11, between edges

      // 1. idle run after reset
      repeat (5) cyc(0, '0, 0, 0, 0);
      chk("t1_pe", 32'(cap_pe), 32'd1);
      chk("t1_fv", 32'(cap_fv), 32'd1);
      chk("t1_bub", 32'(cap_bub), 32'd0);

      // 2. three-cycle stall with zero-cycle release
      repeat (3) begin
         cyc(0, '0, 0, 1, 0);
         chk("t2_pe_held", 32'(cap_pe), 32'd0);
         chk("t2_fv_held", 32'(cap_fv), 32'd1);
      end
      cyc(0, '0, 0, 0, 0);
      chk("t2_pe_release", 32'(cap_pe), 32'd1);
      chk("t2_bub", 32'(cap_bub), 32'd3);

      // 3. taken branch in RUN
      bub_before = int'(bubble_count);
      cyc(1, 11'h1A4, 0, 0, 0);
      chk("t3_jump", 32'(cap_jump), 32'h1A4);
      chk("t3_ps", 32'(cap_ps), 32'd1);
      chk("t3_fl", 32'(cap_fl), 32'd1);
      repeat (2) begin
         cyc(0, '0, 0, 0, 0);
         chk("t3_squash_fl", 32'(cap_fl), 32'd1);
         chk("t3_squash_fv", 32'(cap_fv), 32'd0);
      end
      cyc(0, '0, 0, 0, 0);
      chk("t3_run_fv", 32'(cap_fv), 32'd1);
      chk("t3_run_fl", 32'(cap_fl), 32'd0);
      chk("t3_bub_delta", 32'(int'(cap_bub) - bub_before), 32'd3);

      // 4. inputs pulsed during REDIRECT are ignored
      cyc(1, 11'h0F0, 0, 0, 0);
      cyc(1, 11'h055, 1, 1, 0);
      chk("t4_ps_ignored", 32'(cap_ps), 32'd0);
      cyc(0, '0, 1, 1, 0);
      chk("t4_pe_ignored", 32'(cap_pe), 32'd1);
      cyc(0, '0, 0, 0, 0);
      chk("t4_on_schedule", 32'(cap_fv), 32'd1);

      // 5. stop+stall -> HALT, restart, branch out of HALT
      cyc(0, '0, 1, 1, 0);
      cyc(0, '0, 0, 0, 0);
      chk("t5_halted", 32'(cap_ha), 32'd1);
      chk("t5_pe", 32'(cap_pe), 32'd0);
      cyc(0, '0, 0, 0, 1);
      cyc(0, '0, 0, 0, 0);
      chk("t5_restart", 32'(cap_fv), 32'd1);
      chk("t5_unhalted", 32'(cap_ha), 32'd0);
      cyc(0, '0, 1, 0, 0);
      cyc(1, 11'h2F0, 0, 0, 0);
      chk("t5_halt_redirect", 32'(cap_ps), 32'd1);
      repeat (2) cyc(0, '0, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      chk("t5_halt_redirect_run", 32'(cap_fv), 32'd1);

      // 6. asynchronous reset mid-REDIRECT
      cyc(1, 11'h3AB, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk_reset_outputs("t6_async");
      model_reset();
      @(posedge clk);
      #1;
      chk_reset_outputs("t6_held");
      #2 reset = 1'b1;
      repeat (3) begin
         cyc(0, '0, 0, 0, 0);
         chk("t6_no_residual_flush", 32'(cap_fl), 32'd0);
      end

      // 6 (cont). bubble counter saturation
      cyc(0, '0, 1, 0, 0);
      repeat (BUB_MAX + 8) cyc(0, '0, 0, 0, 0);
      chk("t6_saturate", 32'(bubble_count), 32'(BUB_MAX));
      cyc(0, '0, 0, 0, 1);

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 7) == 0), BW'($urandom),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
